// File: rtl/param_plru_ctrl.sv
// Tree pseudo-LRU replacement controller.
// Sits in front of the per-set PLRU state array: drives the read index, takes
// the combinational read data, and issues one registered write per update.
// A hit marks the hitting way MRU. A miss latches a victim, holds it until the
// fill finishes, and then marks the victim MRU.
module param_plru_ctrl #(
  parameter int Ways      = 4,
  parameter int Sets      = 8,
  parameter int Set_index = $clog2(Sets) - 1,
  parameter int Width     = Ways - 1,
  parameter int Way_bits  = $clog2(Ways)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc_valid,
  input  logic [Set_index:0]   acc_index,
  input  logic                 acc_hit,
  input  logic [Way_bits-1:0]  acc_way,
  input  logic                 fill_done,
  input  logic [Width-1:0]     lru_rdata,
  output logic [Set_index:0]   lru_rindex,
  output logic                 lru_load,
  output logic [Set_index:0]   lru_windex,
  output logic [Width-1:0]     lru_wdata,
  output logic [Way_bits-1:0]  victim_way,
  output logic                 victim_valid,
  output logic                 busy
);

  typedef enum logic {IDLE = 1'b0, MISS_WAIT = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [Set_index:0]   miss_idx_q, miss_idx_d;
  logic [Way_bits-1:0]  victim_q, victim_d;
  logic                 vvalid_q, vvalid_d;
  logic                 load_q, load_d;
  logic [Set_index:0]   windex_q, windex_d;
  logic [Width-1:0]     wdata_q, wdata_d;
  logic [Width-1:0]     eff;

  // Walk root-to-leaf along way w; each visited node is pointed away from w.
  // At depth d the way goes right when its bit (Way_bits-1-d) is set.
  function automatic logic [Width-1:0] plru_update(input logic [Width-1:0]    s,
                                                   input logic [Way_bits-1:0] w);
    logic [Width-1:0] r;
    int               node;
    r    = s;
    node = 0;
    for (int d = 0; d < Way_bits; d++) begin
      r[node] = ~w[Way_bits-1-d];
      node    = 2 * node + 1 + int'(w[Way_bits-1-d]);
    end
    return r;
  endfunction

  // Follow the tree bits from the root; the direction taken at each depth
  // is the corresponding way-index bit.
  function automatic logic [Way_bits-1:0] plru_victim(input logic [Width-1:0] s);
    logic [Way_bits-1:0] v;
    int                  node;
    v    = '0;
    node = 0;
    for (int d = 0; d < Way_bits; d++) begin
      v[Way_bits-1-d] = s[node];
      node            = 2 * node + 1 + int'(s[node]);
    end
    return v;
  endfunction

  // Read index follows the access in IDLE and sticks to the miss set otherwise.
  always_comb begin
    lru_rindex = (state_q == MISS_WAIT) ? miss_idx_q : acc_index;
  end

  // Forward the in-flight write when it targets the set being read, since the
  // array has not committed it yet.
  always_comb begin
    eff = (load_q && (windex_q == lru_rindex)) ? wdata_q : lru_rdata;
  end

  // Next-state and update scheduling.
  always_comb begin
    state_d    = state_q;
    miss_idx_d = miss_idx_q;
    victim_d   = victim_q;
    vvalid_d   = vvalid_q;
    load_d     = 1'b0;
    windex_d   = windex_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        if (acc_valid) begin
          if (acc_hit) begin
            load_d   = 1'b1;
            windex_d = acc_index;
            wdata_d  = plru_update(eff, acc_way);
          end else begin
            miss_idx_d = acc_index;
            victim_d   = plru_victim(eff);
            vvalid_d   = 1'b1;
            state_d    = MISS_WAIT;
          end
        end
      end
      MISS_WAIT: begin
        if (fill_done) begin
          load_d   = 1'b1;
          windex_d = miss_idx_q;
          wdata_d  = plru_update(eff, victim_q);
          vvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, victim and write-stage registers; reset drops any pending work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      miss_idx_q <= '0;
      victim_q   <= '0;
      vvalid_q   <= 1'b0;
      load_q     <= 1'b0;
      windex_q   <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      miss_idx_q <= miss_idx_d;
      victim_q   <= victim_d;
      vvalid_q   <= vvalid_d;
      load_q     <= load_d;
      windex_q   <= windex_d;
      wdata_q    <= wdata_d;
    end
  end

  assign lru_load     = load_q;
  assign lru_windex   = windex_q;
  assign lru_wdata    = wdata_q;
  assign victim_way   = victim_q;
  assign victim_valid = vvalid_q;
  assign busy         = vvalid_q;

endmodule

// File: tb/tb_param_plru_ctrl.sv
// Directed bench for param_plru_ctrl (Ways=4, Sets=8). One table row per
// clock: inputs applied after the falling edge, registered outputs compared
// just after the following rising edge.
module tb_param_plru_ctrl;

  logic       clk;
  logic       rst;
  logic       acc_valid;
  logic [2:0] acc_index;
  logic       acc_hit;
  logic [1:0] acc_way;
  logic       fill_done;
  logic [2:0] lru_rdata;
  logic [2:0] lru_rindex;
  logic       lru_load;
  logic [2:0] lru_windex;
  logic [2:0] lru_wdata;
  logic [1:0] victim_way;
  logic       victim_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  param_plru_ctrl #(.Ways(4), .Sets(8)) dut (
    .clk(clk), .rst(rst),
    .acc_valid(acc_valid), .acc_index(acc_index), .acc_hit(acc_hit),
    .acc_way(acc_way), .fill_done(fill_done), .lru_rdata(lru_rdata),
    .lru_rindex(lru_rindex), .lru_load(lru_load), .lru_windex(lru_windex),
    .lru_wdata(lru_wdata), .victim_way(victim_way),
    .victim_valid(victim_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, av;
    logic [2:0] idx;
    logic       hit;
    logic [1:0] way;
    logic       fd;
    logic [2:0] rd;
    logic       e_load;
    logic [2:0] e_wi, e_wd;
    logic [1:0] e_vw;
    logic       e_vv, e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic av, input logic [2:0] idx,
                              input logic hit, input logic [1:0] way, input logic fd,
                              input logic [2:0] rd, input logic el, input logic [2:0] ewi,
                              input logic [2:0] ewd, input logic [1:0] evw,
                              input logic evv, input logic eb);
    vec_t v;
    v.rst = r; v.av = av; v.idx = idx; v.hit = hit; v.way = way; v.fd = fd; v.rd = rd;
    v.e_load = el; v.e_wi = ewi; v.e_wd = ewd; v.e_vw = evw; v.e_vv = evv; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; acc_valid = v.av; acc_index = v.idx; acc_hit = v.hit;
    acc_way = v.way; fill_done = v.fd; lru_rdata = v.rd;
  endtask

  initial begin
    // rst av idx hit way fd rdata | load windex wdata vway vvalid busy
    vecs.push_back(mk(1,1,2,1,0,0,3'b000, 0,0,3'b000,0,0,0)); // 0 reset, access ignored
    vecs.push_back(mk(1,1,2,1,0,0,3'b000, 0,0,3'b000,0,0,0)); // 1 reset
    vecs.push_back(mk(0,1,2,1,0,0,3'b000, 1,2,3'b011,0,0,0)); // 2 hit set2 way0
    vecs.push_back(mk(0,0,0,0,0,0,3'b000, 0,0,3'b000,0,0,0)); // 3 load drops
    vecs.push_back(mk(0,1,5,0,0,0,3'b011, 0,0,3'b000,2,1,1)); // 4 miss set5 -> way2
    vecs.push_back(mk(0,0,0,0,0,0,3'b011, 0,0,3'b000,2,1,1)); // 5 waiting
    vecs.push_back(mk(0,0,0,0,0,0,3'b011, 0,0,3'b000,2,1,1)); // 6 waiting
    vecs.push_back(mk(0,0,0,0,0,1,3'b011, 1,5,3'b110,0,0,0)); // 7 fill -> 110
    vecs.push_back(mk(0,0,0,0,0,0,3'b000, 0,0,3'b000,0,0,0)); // 8
    vecs.push_back(mk(0,1,1,1,0,0,3'b000, 1,1,3'b011,0,0,0)); // 9 hit set1 way0
    vecs.push_back(mk(0,1,1,1,3,0,3'b000, 1,1,3'b010,0,0,0)); // 10 bypass way3
    vecs.push_back(mk(0,0,0,0,0,0,3'b000, 0,0,3'b000,0,0,0)); // 11
    vecs.push_back(mk(0,1,1,1,0,0,3'b000, 1,1,3'b011,0,0,0)); // 12 hit set1 way0
    vecs.push_back(mk(0,1,4,1,3,0,3'b000, 1,4,3'b000,0,0,0)); // 13 other set, no bypass
    vecs.push_back(mk(0,0,0,0,0,0,3'b000, 0,0,3'b000,0,0,0)); // 14
    vecs.push_back(mk(0,1,6,0,0,0,3'b101, 0,0,3'b000,3,1,1)); // 15 miss set6 -> way3
    vecs.push_back(mk(0,1,6,1,1,0,3'b101, 0,0,3'b000,3,1,1)); // 16 hit ignored
    vecs.push_back(mk(0,1,0,0,0,0,3'b101, 0,0,3'b000,3,1,1)); // 17 miss ignored
    vecs.push_back(mk(0,0,0,0,0,1,3'b101, 1,6,3'b000,0,0,0)); // 18 fill -> 000
    vecs.push_back(mk(0,0,0,0,0,1,3'b000, 0,0,3'b000,0,0,0)); // 19 fill_done in IDLE
    vecs.push_back(mk(0,0,0,0,0,0,3'b000, 0,0,3'b000,0,0,0)); // 20
    vecs.push_back(mk(0,1,3,0,0,0,3'b010, 0,0,3'b000,1,1,1)); // 21 miss set3 -> way1
    vecs.push_back(mk(1,0,0,0,0,0,3'b010, 0,0,3'b000,0,0,0)); // 22 reset mid-miss
    vecs.push_back(mk(0,0,0,0,0,1,3'b010, 0,0,3'b000,0,0,0)); // 23 stale fill ignored
    vecs.push_back(mk(0,1,7,1,2,0,3'b111, 1,7,3'b110,0,0,0)); // 24 hit set7 way2

    drive(vecs[0]);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d lru_load", i), 32'(lru_load), 32'(vecs[i].e_load));
      chk($sformatf("row%0d victim_valid", i), 32'(victim_valid), 32'(vecs[i].e_vv));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      if (vecs[i].e_load || vecs[i].rst) begin
        chk($sformatf("row%0d lru_windex", i), 32'(lru_windex), 32'(vecs[i].e_wi));
        chk($sformatf("row%0d lru_wdata", i), 32'(lru_wdata), 32'(vecs[i].e_wd));
      end
      if (vecs[i].e_vv || vecs[i].rst)
        chk($sformatf("row%0d victim_way", i), 32'(victim_way), 32'(vecs[i].e_vw));
    end

    // Read index tracks acc_index in IDLE, then the miss set; fill_done in the
    // very first MISS_WAIT cycle is honoured.
    @(negedge clk);
    drive(mk(0,1,5,0,0,0,3'b000, 0,0,0,0,0,0));
    #1 chk("seq rindex idle", 32'(lru_rindex), 32'd5);
    @(posedge clk); #1;
    chk("seq miss victim_way", 32'(victim_way), 32'd0);
    chk("seq miss busy", 32'(busy), 32'd1);
    @(negedge clk);
    drive(mk(0,1,2,1,3,1,3'b000, 0,0,0,0,0,0));
    #1 chk("seq rindex miss", 32'(lru_rindex), 32'd5);
    @(posedge clk); #1;
    chk("seq early fill load", 32'(lru_load), 32'd1);
    chk("seq early fill windex", 32'(lru_windex), 32'd5);
    chk("seq early fill wdata", 32'(lru_wdata), 32'h3);
    chk("seq early fill busy", 32'(busy), 32'd0);
    @(negedge clk);
    drive(mk(0,0,0,0,0,0,3'b000, 0,0,0,0,0,0));
    @(posedge clk); #1;
    chk("seq after fill load", 32'(lru_load), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
